// File: rtl/ifm_buf_loader_if.sv
// Stream-in and dual input-buffer write bus for the IFM buffer loader.
// Handshake: a stream beat transfers on a rising edge where s_valid && s_ready
// are both high; s_data must be stable whenever s_valid is high, and s_valid
// may rise or fall at any time without waiting for s_ready.
interface ifm_buf_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_W      = 10
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  logic                  in_buf_0_write_n;
  logic [ADR_W-1:0]      in_buf_0_address;
  logic [DATA_WIDTH-1:0] in_buf_0_writedata;

  logic                  in_buf_1_write_n;
  logic [ADR_W-1:0]      in_buf_1_address;
  logic [DATA_WIDTH-1:0] in_buf_1_writedata;

  // Environment side: drives the stream, observes the buffer writes.
  modport master (
    output s_valid, s_data,
    input  s_ready,
    input  in_buf_0_write_n, in_buf_0_address, in_buf_0_writedata,
    input  in_buf_1_write_n, in_buf_1_address, in_buf_1_writedata
  );

  // Loader side: consumes the stream, drives the buffer writes.
  modport slave (
    input  s_valid, s_data,
    output s_ready,
    output in_buf_0_write_n, in_buf_0_address, in_buf_0_writedata,
    output in_buf_1_write_n, in_buf_1_address, in_buf_1_writedata
  );
endinterface

// File: rtl/ifm_buf_loader.sv
// IFM buffer loader: streams one channel tile (or two) into the input
// buffers, zero-fills buffer 1 for single-channel tiles, then kicks the
// convolution engine and waits for it to finish.
module ifm_buf_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_W      = 10,
  parameter int DEPTH      = 784
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             two_ch,
  input  logic             conv_done,
  output logic             conv_enable,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg,
  ifm_buf_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD0 = 3'd1,
    LOAD1 = 3'd2,
    ZERO1 = 3'd3,
    FLUSH = 3'd4,
    KICK  = 3'd5,
    WAIT  = 3'd6
  } state_t;

  localparam logic [ADR_W-1:0] LAST = ADR_W'(DEPTH - 1);
  localparam logic [ADR_W-1:0] ONE  = ADR_W'(1);

  state_t                state;
  logic [ADR_W-1:0]      cnt;
  logic                  two_ch_q;
  logic                  wr_n0;
  logic [ADR_W-1:0]      adr0;
  logic [DATA_WIDTH-1:0] wd0;
  logic                  wr_n1;
  logic [ADR_W-1:0]      adr1;
  logic [DATA_WIDTH-1:0] wd1;
  logic                  kick_q;
  logic                  done_q;
  logic                  beat;
  logic                  at_last;

  // Stream is only accepted while a channel is being loaded.
  assign bus.s_ready = (state == LOAD0) || (state == LOAD1);
  assign beat        = bus.s_valid && bus.s_ready;
  assign at_last     = (cnt == LAST);

  assign bus.in_buf_0_write_n   = wr_n0;
  assign bus.in_buf_0_address   = adr0;
  assign bus.in_buf_0_writedata = wd0;
  assign bus.in_buf_1_write_n   = wr_n1;
  assign bus.in_buf_1_address   = adr1;
  assign bus.in_buf_1_writedata = wd1;

  assign conv_enable = kick_q;
  assign done        = done_q;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  // Tile sequencer with registered write port, kick and done outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      two_ch_q <= 1'b0;
      wr_n0    <= 1'b1;
      adr0     <= '0;
      wd0      <= '0;
      wr_n1    <= 1'b1;
      adr1     <= '0;
      wd1      <= '0;
      kick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Strobes and pulses drop unless re-asserted below; address and data
      // hold their last value between writes.
      wr_n0  <= 1'b1;
      wr_n1  <= 1'b1;
      kick_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            two_ch_q <= two_ch;
            cnt      <= '0;
            state    <= LOAD0;
          end
        end
        LOAD0: begin
          if (beat) begin
            wr_n0 <= 1'b0;
            adr0  <= cnt;
            wd0   <= bus.s_data;
            if (at_last) begin
              cnt   <= '0;
              state <= two_ch_q ? LOAD1 : ZERO1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        LOAD1: begin
          if (beat) begin
            wr_n1 <= 1'b0;
            adr1  <= cnt;
            wd1   <= bus.s_data;
            if (at_last) begin
              cnt   <= '0;
              state <= FLUSH;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        ZERO1: begin
          // One zero word per cycle, no stream involvement.
          wr_n1 <= 1'b0;
          adr1  <= cnt;
          wd1   <= {DATA_WIDTH{1'b0}};
          if (at_last) begin
            cnt   <= '0;
            state <= FLUSH;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        FLUSH: begin
          // The last registered write is on the bus during this cycle.
          kick_q <= 1'b1;
          state  <= KICK;
        end
        KICK: begin
          state <= WAIT;
        end
        WAIT: begin
          if (conv_done) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_buf_loader.sv
// Directed bench for ifm_buf_loader with DEPTH=4 and a write scoreboard.
module tb_ifm_buf_loader;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int W     = 1 + AW + DW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD0 = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd6;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       two_ch;
  logic       conv_done;
  logic       conv_enable;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  ifm_buf_loader_if #(.DATA_WIDTH(DW), .ADR_W(AW)) bus ();

  ifm_buf_loader #(.DATA_WIDTH(DW), .ADR_W(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .two_ch      (two_ch),
    .conv_done   (conv_done),
    .conv_enable (conv_enable),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg),
    .bus         (bus)
  );

  // Clock
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] didx;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every presented write must match the head of the queue.
  always @(negedge clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    if (bus.in_buf_0_write_n === 1'b0 || bus.in_buf_1_write_n === 1'b0) begin
      if (bus.in_buf_1_write_n === 1'b0)
        obs = {1'b1, bus.in_buf_1_address, bus.in_buf_1_writedata};
      else
        obs = {1'b0, bus.in_buf_0_address, bus.in_buf_0_writedata};
      if (exp_q.size() == 0) begin
        chk("write_pending", 64'(exp_q.size()), 64'd1);
      end else begin
        exp = exp_q.pop_front();
        chk("write", 64'(obs), 64'(exp));
      end
    end
  end

  // One clock; advances the stream word after an accepted beat.
  task automatic step();
    logic acc;
    acc = bus.s_valid && bus.s_ready;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
    if (acc) begin
      didx = didx + 32'd1;
      bus.s_data = didx;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, 64'(state_dbg), 64'(S_IDLE));
    chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    chk({tag, "_wn0"}, 64'(bus.in_buf_0_write_n), 64'd1);
    chk({tag, "_wn1"}, 64'(bus.in_buf_1_write_n), 64'd1);
    chk({tag, "_adr0"}, 64'(bus.in_buf_0_address), 64'd0);
    chk({tag, "_adr1"}, 64'(bus.in_buf_1_address), 64'd0);
    chk({tag, "_wd0"}, 64'(bus.in_buf_0_writedata), 64'd0);
    chk({tag, "_wd1"}, 64'(bus.in_buf_1_writedata), 64'd0);
    chk({tag, "_conv_enable"}, 64'(conv_enable), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // One always-valid tile from the start cycle (cycle 0) to cycle 12 (WAIT).
  task automatic run_tile(input logic tc, input logic [31:0] base);
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back({1'b0, AW'(i), base + 32'(i)});
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back({1'b1, AW'(i), tc ? base + 32'(DEPTH + i) : 32'd0});
    two_ch      = tc;
    start       = 1'b1;
    bus.s_valid = 1'b1;
    didx        = base;
    bus.s_data  = base;
    cyc         = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      start = 1'b0;
      if (cyc == 1) chk("state_load0", 64'(state_dbg), 64'(S_LOAD0));
      if (cyc == 9) chk("state_flush", 64'(state_dbg), 64'(S_FLUSH));
      if (cyc == 12) chk("state_wait", 64'(state_dbg), 64'(S_WAIT));
      chk("conv_enable", 64'(conv_enable), 64'(cyc == 10));
      chk("busy", 64'(busy), 64'd1);
      chk("wn0", 64'(bus.in_buf_0_write_n), 64'(!(cyc >= 2 && cyc <= 5)));
      chk("wn1", 64'(bus.in_buf_1_write_n), 64'(!(cyc >= 6 && cyc <= 9)));
      if (cyc == 10) chk("queue_drained", 64'(exp_q.size()), 64'd0);
    end
    bus.s_valid = 1'b0;
  endtask

  // Hold in WAIT, optionally pulsing start, then complete the tile.
  task automatic finish_wait(input int hold, input logic poke_start);
    for (int i = 0; i < hold; i++) begin
      conv_done = 1'b0;
      start     = poke_start && (i == 5);
      step();
      chk("wait_busy", 64'(busy), 64'd1);
      chk("wait_state", 64'(state_dbg), 64'(S_WAIT));
      chk("wait_done", 64'(done), 64'd0);
    end
    start     = 1'b0;
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_state", 64'(state_dbg), 64'(S_IDLE));
    step();
    chk("done_clear", 64'(done), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    two_ch      = 1'b0;
    conv_done   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    didx        = '0;
    step();
    step();
    check_reset("por");
    reset = 1'b0;
    step();

    // conv_done while idle is ignored
    conv_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_cd_state", 64'(state_dbg), 64'(S_IDLE));
      chk("idle_cd_done", 64'(done), 64'd0);
    end
    conv_done = 1'b0;

    // Two-channel tile, values 1..8
    run_tile(1'b1, 32'd1);
    finish_wait(2, 1'b0);

    // Single-channel tile, values 9..12 with zero-filled buffer 1,
    // then a long WAIT with a stray start
    run_tile(1'b0, 32'd9);
    finish_wait(20, 1'b1);
    chk("no_reload", 64'(bus.s_ready), 64'd0);

    // Gapped stream: valid 1,0,1,0 gives two writes at addresses 0 and 1
    exp_q.push_back({1'b0, AW'(0), 32'h0000_00a0});
    exp_q.push_back({1'b0, AW'(1), 32'h0000_00a1});
    two_ch = 1'b1;
    start  = 1'b1;
    cyc    = 0;
    step();
    start = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h0000_00a0;
    step();
    chk("gap_wn0_beat0", 64'(bus.in_buf_0_write_n), 64'd0);
    bus.s_valid = 1'b0;
    conv_done   = 1'b1;
    step();
    chk("gap_wn0_gap0", 64'(bus.in_buf_0_write_n), 64'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h0000_00a1;
    step();
    chk("gap_wn0_beat1", 64'(bus.in_buf_0_write_n), 64'd0);
    bus.s_valid = 1'b0;
    step();
    chk("gap_wn0_gap1", 64'(bus.in_buf_0_write_n), 64'd1);
    chk("gap_adr_hold", 64'(bus.in_buf_0_address), 64'd1);
    chk("load_cd_state", 64'(state_dbg), 64'(S_LOAD0));
    chk("load_cd_done", 64'(done), 64'd0);
    conv_done = 1'b0;

    // Reset mid-load, then a fresh tile must restart at address 0
    reset = 1'b1;
    step();
    check_reset("mid_load");
    reset = 1'b0;
    chk("reset_queue", 64'(exp_q.size()), 64'd0);
    run_tile(1'b1, 32'h0000_0100);

    // Reset in WAIT wins over a simultaneous conv_done
    reset     = 1'b1;
    conv_done = 1'b1;
    step();
    check_reset("wait");
    reset     = 1'b0;
    conv_done = 1'b0;
    step();
    chk("wait_reset_no_done", 64'(done), 64'd0);
    chk("wait_reset_idle", 64'(state_dbg), 64'(S_IDLE));
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifm_buf_loader.md
IFM_BUF_LOADER -- requirements
Module: ifm_buf_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of one buffer word.
REQ-002 Parameter ADR_W, default 10, SHALL set the input-buffer address width.
REQ-003 Parameter DEPTH, default 784, SHALL set the words per channel tile (Win*Hin); DEPTH SHALL lie in 1..2^ADR_W.
REQ-004 clk  input  1  SHALL be the single clock; all logic SHALL be rising-edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 start  input  1  SHALL request one load-and-convolve tile; sampled only in IDLE.
REQ-007 two_ch  input  1  SHALL select the channel count: 1 = two channels; 0 = one channel, with buffer 1 zero-filled. Sampled with start.
REQ-008 s_valid  input  1  SHALL mark a valid stream word.
REQ-009 s_data  input  DATA_WIDTH  SHALL carry the stream word.
REQ-010 s_ready  output  1  SHALL mark that the block accepts a word; a beat transfers when s_valid && s_ready.
REQ-011 in_buf_k_write_n (k=0,1)  output  1  SHALL be the active-low write strobe for input buffer k.
REQ-012 in_buf_k_address  output  ADR_W  SHALL be the buffer k write address.
REQ-013 in_buf_k_writedata  output  DATA_WIDTH  SHALL be the buffer k write data.
REQ-014 conv_enable  output  1  SHALL be the start pulse to the convolution engine.
REQ-015 conv_done  input  1  SHALL be the convolution-engine completion flag.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.
REQ-017 done  output  1  SHALL pulse high for one cycle when the tile completes.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD0, LOAD1, ZERO1, FLUSH, KICK and WAIT.
REQ-019 In IDLE, start=1 SHALL latch two_ch, clear the address counter and enter LOAD0 on the next edge; start in any other state SHALL be ignored.
REQ-020 s_ready SHALL be combinational and equal to 1 only in LOAD0 or LOAD1.
REQ-021 Each accepted beat at edge t SHALL drive the selected buffer at cycle t+1 with write_n=0, address=counter value at acceptance, writedata=s_data; write_n SHALL return to 1 the cycle after unless another beat was accepted.
REQ-022 In LOAD0, beats SHALL write buffer 0; in LOAD1 and ZERO1, writes SHALL go to buffer 1; the write_n of the unselected buffer SHALL stay 1.
REQ-023 The counter SHALL increment on each accepted beat; with s_valid=0 the counter and outputs SHALL hold, and write_n SHALL be 1.
REQ-024 An accepted beat at counter DEPTH-1 SHALL wrap the counter to 0 and transition LOAD0→LOAD1 if two_ch=1, LOAD0→ZERO1 if two_ch=0, and LOAD1→FLUSH.
REQ-025 ZERO1 SHALL write 0 to buffer 1 at one address per cycle, addresses 0..DEPTH-1, using the same registered timing as REQ-021, then enter FLUSH.
REQ-026 FLUSH SHALL last exactly one cycle, in which the final registered write is presented, then enter KICK.
REQ-027 KICK SHALL last one cycle with conv_enable=1, then enter WAIT; conv_enable SHALL be 0 in every other state.
REQ-028 WAIT SHALL hold until conv_done=1, then enter IDLE with done=1 for that single following cycle.
REQ-029 conv_done outside WAIT SHALL be ignored.
REQ-030 Total latency with an always-valid stream SHALL be: start edge → LOAD0 at +1; 2*DEPTH beat cycles; FLUSH; KICK at cycle 2*DEPTH+2.

Reset
REQ-031 Reset=1 at any edge, including mid-load or in WAIT, SHALL force the following next cycle: state=IDLE, counter=0, s_ready=0, both write_n=1, both addresses=0, both writedata=0, conv_enable=0, busy=0, done=0.
REQ-032 Reset SHALL take priority over start, beats and conv_done in the same cycle.

Verification (DEPTH=4)
REQ-033 two_ch=1, stream values 1..8 always valid → buffer 0 addresses 0..3 receive 1..4 and buffer 1 addresses 0..3 receive 5..8; conv_enable is high exactly at cycle 10 after start.
REQ-034 two_ch=0, values 9..12 → buffer 0 receives 9..12, buffer 1 receives 0 at addresses 0..3 in 4 consecutive cycles, then one FLUSH cycle and a one-cycle conv_enable.
REQ-035 s_valid toggles 1,0,1,0 → only 2 writes occur with addresses 0 and 1, and write_n is high during each gap.
REQ-036 In WAIT, holding conv_done=0 for 20 cycles and then pulsing it → busy stays 1 throughout, then done=1 for one cycle and busy=0; a start pulse issued during WAIT causes no new load.
REQ-037 Reset after the second beat of LOAD0 → next cycle all outputs are at their REQ-031 values; a fresh start then writes from address 0.
REQ-038 conv_done=1 in IDLE or LOAD0 → no state change and no done pulse.
